// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the multi-digit BCD counter.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  // True when a nibble is a legal BCD digit (0..9).
  function automatic logic bcd_valid(input logic [DIGIT_W-1:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

  // Illegal nibbles (A..F) are stored as 0 so the count never holds non-BCD digits.
  function automatic logic [DIGIT_W-1:0] bcd_sanitise(input logic [DIGIT_W-1:0] nibble);
    return bcd_valid(nibble) ? nibble : BCD_MIN;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register. carry_in means "every lower digit is at its
// terminal value", so this digit steps; carry_out passes that on when this
// digit is itself terminal for the current direction.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clock,
  input  logic               clear_n,
  input  logic               enable,
  input  logic               up_down,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  logic at_term;

  // Terminal for the current direction: 9 counting up, 0 counting down.
  always_comb begin
    at_term   = up_down ? (digit == BCD_MAX) : (digit == BCD_MIN);
    carry_out = carry_in & at_term;
  end

  // Digit register: load wins, otherwise step when enabled and carried into.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_sanitise(load_digit);
    end else if (enable && carry_in) begin
      if (up_down) begin
        digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_multi.sv
// Parametrised multi-digit BCD up/down counter with parallel load,
// wrap-or-saturate behaviour and registered wrap / load_error pulses.
module bcd_counter_multi
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                      clock,
  input  logic                      clear_n,
  input  logic                      enable,
  input  logic                      up_down,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_value,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      wrap,
  output logic                      at_limit,
  output logic                      load_error
);

  // carry[i] is high when every digit below i is terminal; carry[0] is always 1
  // so digit 0 steps on every enabled edge. carry[DIGITS] is the whole count
  // being terminal.
  logic [DIGITS:0]   carry;
  logic              step_en;
  logic [DIGITS-1:0] nib_bad;

  assign carry[0] = 1'b1;

  // Saturation is just suppressing the step on the terminal value.
  always_comb begin
    at_limit = carry[DIGITS];
    step_en  = enable & ~(SATURATE & carry[DIGITS]);
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clock      (clock),
      .clear_n    (clear_n),
      .enable     (step_en),
      .up_down    (up_down),
      .load       (load),
      .load_digit (load_value[DIGIT_W*i +: DIGIT_W]),
      .carry_in   (carry[i]),
      .digit      (count[DIGIT_W*i +: DIGIT_W]),
      .carry_out  (carry[i+1])
    );
  end

  // Flag every load nibble that is not a legal BCD digit.
  always_comb begin
    nib_bad = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib_bad[i] = ~bcd_valid(load_value[DIGIT_W*i +: DIGIT_W]);
    end
  end

  // One-cycle status pulses, registered alongside the count update.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wrap       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      wrap       <= ~load & enable & carry[DIGITS] & ~SATURATE;
      load_error <= load & (|nib_bad);
    end
  end

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Bench for bcd_counter_multi: a wrapping and a saturating 2-digit instance
// share one stimulus stream and are checked every cycle against an
// integer-valued model, with directed literal checks at key points.
module tb_bcd_counter_multi;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 99;

  logic         clock = 1'b0;
  logic         clear_n, enable, up_down, load;
  logic [W-1:0] load_value;

  logic [W-1:0] count_w, count_s;
  logic         wrap_w, wrap_s, at_limit_w, at_limit_s, load_error_w, load_error_s;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model state: index 0 = wrapping counter, index 1 = saturating counter.
  int m_val [2];
  bit m_wrap[2];
  bit m_lerr;

  always #5 clock = ~clock;

  bcd_counter_multi #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .clear_n(clear_n), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .count(count_w), .wrap(wrap_w),
    .at_limit(at_limit_w), .load_error(load_error_w)
  );

  bcd_counter_multi #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .clear_n(clear_n), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .count(count_s), .wrap(wrap_s),
    .at_limit(at_limit_s), .load_error(load_error_s)
  );

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int d;
    r = '0;
    d = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  // Decimal value a load produces: each illegal nibble counts as 0.
  function automatic int load_to_int(input logic [W-1:0] lv);
    int v, d, nib;
    v = 0;
    d = 1;
    for (int i = 0; i < DIGITS; i++) begin
      nib = int'(lv[4*i +: 4]);
      if (nib <= 9) v = v + nib * d;
      d = d * 10;
    end
    return v;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] lv);
    bit b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (lv[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: plain decimal arithmetic on an integer count.
  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_val[0] = 0; m_val[1] = 0;
      m_wrap[0] = 1'b0; m_wrap[1] = 1'b0;
      m_lerr = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_wrap[k] = 1'b0;
        if (load) begin
          m_val[k] = load_to_int(load_value);
        end else if (enable) begin
          if (up_down) begin
            if (m_val[k] == MAXV) begin
              if (k == 0) begin m_val[k] = 0; m_wrap[k] = 1'b1; end
            end else m_val[k] = m_val[k] + 1;
          end else begin
            if (m_val[k] == 0) begin
              if (k == 0) begin m_val[k] = MAXV; m_wrap[k] = 1'b1; end
            end else m_val[k] = m_val[k] - 1;
          end
        end
      end
      m_lerr = load && has_bad(load_value);
    end
  end

  // Compare every output of both instances on each falling edge.
  always @(negedge clock) begin
    if (chk_on) begin
      check("count_w", 32'(count_w), 32'(to_bcd(m_val[0])));
      check("count_s", 32'(count_s), 32'(to_bcd(m_val[1])));
      check("wrap_w", 32'(wrap_w), 32'(m_wrap[0]));
      check("wrap_s", 32'(wrap_s), 32'(m_wrap[1]));
      check("lerr_w", 32'(load_error_w), 32'(m_lerr));
      check("lerr_s", 32'(load_error_s), 32'(m_lerr));
      check("at_limit_w", 32'(at_limit_w), 32'(up_down ? (m_val[0] == MAXV) : (m_val[0] == 0)));
      check("at_limit_s", 32'(at_limit_s), 32'(up_down ? (m_val[1] == MAXV) : (m_val[1] == 0)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    load_value = v;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    clear_n = 1'b1; enable = 1'b1; up_down = 1'b1; load = 1'b0; load_value = '0;
    #1 clear_n = 1'b0;
    #1 chk_on = 1'b1;
    #8;
    check("reset_count", 32'(count_w), 32'h00);
    check("reset_wrap", 32'(wrap_w), 32'h0);
    #11 clear_n = 1'b1;

    // 25 edges up from reset
    tick(25);
    check("up25_count", 32'(count_w), 32'h25);
    check("up25_model", 32'(m_val[0]), 32'd25);
    check("up25_wrap", 32'(wrap_w), 32'h0);

    // Roll over from 98 upward
    do_load(8'h98);
    check("ld98", 32'(count_w), 32'h98);
    tick(1);
    check("at99", 32'(count_w), 32'h99);
    check("at99_limit", 32'(at_limit_w), 32'h1);
    tick(1);
    check("roll_00", 32'(count_w), 32'h00);
    check("roll_wrap", 32'(wrap_w), 32'h1);
    check("sat_hold99", 32'(count_s), 32'h99);
    check("sat_nowrap", 32'(wrap_s), 32'h0);
    tick(1);
    check("after_roll", 32'(count_w), 32'h01);
    check("wrap_once", 32'(wrap_w), 32'h0);

    // Down roll from 00
    do_load(8'h00);
    up_down = 1'b0;
    tick(1);
    check("down_99", 32'(count_w), 32'h99);
    check("down_wrap", 32'(wrap_w), 32'h1);
    check("sat_down_hold", 32'(count_s), 32'h00);
    tick(1);
    check("down_98", 32'(count_w), 32'h98);
    check("down_wrap_clr", 32'(wrap_w), 32'h0);

    // Load beats enable; invalid nibble sanitised
    up_down = 1'b1;
    do_load(8'h7A);
    check("ld7a_count", 32'(count_w), 32'h70);
    check("ld7a_lerr", 32'(load_error_w), 32'h1);
    do_load(8'h42);
    check("ld42_count", 32'(count_w), 32'h42);
    check("ld42_lerr", 32'(load_error_w), 32'h0);

    // Asynchronous clear mid-cycle
    do_load(8'h37);
    #2 clear_n = 1'b0;
    #1 check("async_clr", 32'(count_w), 32'h00);
    #9 clear_n = 1'b1;
    tick(1);
    check("resume_01", 32'(count_w), 32'h01);

    // Saturating instance holds at 99 then counts down
    do_load(8'h99);
    tick(5);
    check("sat_99", 32'(count_s), 32'h99);
    check("sat_wrap0", 32'(wrap_s), 32'h0);
    up_down = 1'b0;
    tick(1);
    check("sat_98", 32'(count_s), 32'h98);

    // Randomised phase
    for (int c = 0; c < 400; c++) begin
      enable     = 1'($urandom_range(0, 3) != 0);
      up_down    = 1'($urandom_range(0, 1));
      load       = 1'($urandom_range(0, 7) == 0);
      load_value = ($urandom_range(0, 3) == 0) ? W'($urandom) : to_bcd(int'($urandom_range(0, MAXV)));
      if ($urandom_range(0, 3) == 0) load_value = ($urandom_range(0, 1) == 1) ? 8'h99 : 8'h00;
      if ($urandom_range(0, 60) == 0) begin
        #3 clear_n = 1'b0;
        #4 clear_n = 1'b1;
      end
      tick(1);
    end

    load = 1'b0;
    enable = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
Parametrised multi-digit BCD counter. Successor to the single-digit 4-bit BCD counter.
Adds a configurable digit count, up/down direction, count enable, synchronous parallel load with BCD validation, and wrap-or-saturate mode.
Registered wrap/error flags. Used for decimal event counts, display timers and the BCD prescaler chain.

Parameters:
DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS.
SATURATE, 0, 0 = wrap at terminal value; 1 = hold at terminal value.

Ports:
clock  input  1  rising-edge clock
clear_n  input  1  asynchronous active-low reset
enable  input  1  count enable, sampled on the rising edge
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load; takes priority over enable
load_value  input  4*DIGITS  BCD value to load; digit i is bits [4i+3:4i]
count  output  4*DIGITS  current BCD count, registered
wrap  output  1  registered one-cycle pulse on terminal roll-over
at_limit  output  1  combinational; count is at the terminal value for the current direction (all 9s up, all 0s down)
load_error  output  1  registered one-cycle pulse when a loaded nibble was >9

Behaviour:
- Reset (clear_n low, asynchronous, any time including mid-count): count=0, wrap=0, load_error=0. Release is synchronous to clock; the first count/load takes effect on the first rising edge with clear_n high.
- Priority on each rising edge: load > enable > hold.
- Load, per digit:
  - nibble <=9 → loaded as-is.
  - nibble >9 → digit forced to 0.
  - load_error=1 on the next cycle if any nibble was >9, else 0.
  - wrap=0 on a load cycle.
- Count up (enable=1, up_down=1):
  - digit 0 always steps.
  - digit i steps iff all lower digits ==9.
  - a stepping digit goes 9→0, otherwise +1.
- Count down (enable=1, up_down=0):
  - digit i steps iff all lower digits ==0.
  - a stepping digit goes 0→9, otherwise -1.
- Terminal value: all digits 9 when counting up; all digits 0 when counting down.
- Terminal, SATURATE=0: count rolls to all-0 (up) or all-9 (down); wrap=1 for exactly one cycle after that edge.
- Terminal, SATURATE=1: count holds; wrap stays 0.
- enable=0 and load=0: count holds; wrap=0 and load_error=0 next cycle.
- Direction may change on any cycle; a change takes effect on the same edge. There is no hysteresis.
- Invariant: every count nibble is always in 0..9. Only load can introduce out-of-range values, and they are sanitised before being stored.
- Latency: one clock from enable/load to count update. at_limit is combinational from count and up_down; it has no enable term.

Decomposition:
- Shared package bcd_pkg: BCD_MAX=4'd9, BCD_MIN=4'd0, DIGIT_W=4, and the function bcd_sanitise(nibble).
- Sub-module bcd_digit: a single 4-bit digit register with enable, up_down, load, load_digit, carry_in (step), carry_out (at 9 when up / at 0 when down). It has asynchronous active-low reset on clock/clear_n.
- bcd_counter_multi generate-instantiates DIGITS copies and chains carry_out → carry_in. It also owns the wrap, load_error and at_limit logic.

Test Plan:
- DIGITS=2, SATURATE=0: hold clear_n=0 for 20 ns, then release with enable=1, up_down=1 → count=00 during reset; after 25 edges count=25, wrap=0 throughout.
- From count=98, up, 2 edges → 99 then 00. at_limit=1 while at 99. wrap=1 for exactly the one cycle after reaching 00.
- From count=00, up_down=0, enable=1, 1 edge → count=99, wrap pulses once. A further edge → 98.
- load_value=8'h7A, load=1 with enable=1 → count=70 (load wins, low nibble sanitised), load_error=1 for one cycle. Then load_value=8'h42 → count=42, load_error=0.
- Counting up at count=37, pull clear_n low mid-cycle for 10 ns → count=00 immediately (asynchronous, before the next edge). Counting resumes 01 on the first edge after release.
- SATURATE=1, count=99, up, 5 edges → count stays 99, wrap=0. Switch to up_down=0 → 98 on the next edge.
